// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and width helpers for the sequential divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DVD_W_DEFAULT = 8;
    localparam int DVS_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Step counter width: enough to count 0 .. dvd_w-1 without wrapping.
    function automatic int cnt_w(input int dvd_w);
        return $clog2(dvd_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One restoring-division step. Shifts the next dividend bit
//                into the partial remainder and subtracts the divisor when it
//                fits, producing the next remainder and one quotient bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int DVS_W = 4
) (
    input  logic [DVS_W:0]   rem,
    input  logic             msb,
    input  logic [DVS_W-1:0] dvs,
    output logic [DVS_W:0]   rem_next,
    output logic             q_bit
);

    logic [DVS_W:0] w_trial;
    logic [DVS_W:0] w_dvs_ext;
    // The partial remainder is always below the divisor, so its top bit is
    // always zero and drops out of the shift.
    logic           w_unused_rem_top;

    assign w_trial          = {rem[DVS_W-1:0], msb};
    assign w_dvs_ext        = {1'b0, dvs};
    assign w_unused_rem_top = rem[DVS_W];

    // Subtract when the divisor fits, otherwise restore (keep the trial value).
    always_comb begin
        q_bit    = 1'b0;
        rem_next = w_trial;
        if (w_trial >= w_dvs_ext) begin
            q_bit    = 1'b1;
            rem_next = w_trial - w_dvs_ext;
        end
    end

endmodule
`default_nettype wire

// File: rtl/divider_sequential.sv
`default_nettype none
// ============================================================================
//  Module      : divider_sequential
//  Description : Iterative unsigned restoring divider, one quotient bit per
//                clock, with start/busy/done handshake. Divide-by-zero
//                completes immediately with an all-ones quotient.
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_sequential
    import div_pkg::*;
#(
    parameter int DVD_W = DVD_W_DEFAULT,
    parameter int DVS_W = DVS_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_by_zero
);

    localparam int             CNT_W      = cnt_w(DVD_W);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DVD_W - 1);

    div_state_t       r_state;
    div_state_t       w_state_next;
    logic [DVD_W-1:0] r_q;
    logic [DVS_W:0]   r_r;
    logic [DVS_W-1:0] r_d;
    logic [CNT_W-1:0] r_cnt;
    logic [DVS_W:0]   w_rem_next;
    logic             w_q_bit;
    logic             w_dvs_zero;
    logic             w_last;
    logic [DVD_W-1:0] w_q_next;

    assign w_dvs_zero = (divisor == '0);
    assign w_last     = (r_cnt == c_cnt_last);
    assign w_q_next   = {r_q[DVD_W-2:0], w_q_bit};

    div_step #(
        .DVS_W(DVS_W)
    ) u_step (
        .rem      (r_r),
        .msb      (r_q[DVD_W-1]),
        .dvs      (r_d),
        .rem_next (w_rem_next),
        .q_bit    (w_q_bit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs decoded from the current state.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = w_dvs_zero ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and held result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q         <= '0;
            r_r         <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_dvs_zero) begin
                            quotient    <= '1;
                            remainder   <= dividend[DVS_W-1:0];
                            div_by_zero <= 1'b1;
                        end else begin
                            r_q   <= dividend;
                            r_r   <= '0;
                            r_d   <= divisor;
                            r_cnt <= '0;
                        end
                    end
                end
                RUN: begin
                    r_q <= w_q_next;
                    r_r <= w_rem_next;
                    if (w_last) begin
                        quotient    <= w_q_next;
                        remainder   <= w_rem_next[DVS_W-1:0];
                        div_by_zero <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_divider_sequential.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider_sequential
//  Description : Self-checking bench for divider_sequential: vector table,
//                hand-written handshake corner cases and randomized operands
//                against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_sequential;

    localparam int DVD_W = 8;
    localparam int DVS_W = 4;
    localparam int TIMEOUT = 40;

    logic             clk;
    logic             rst;
    logic             start;
    logic [DVD_W-1:0] dividend;
    logic [DVS_W-1:0] divisor;
    logic             busy;
    logic             done;
    logic [DVD_W-1:0] quotient;
    logic [DVS_W-1:0] remainder;
    logic             div_by_zero;

    int n_checks;
    int n_fails;

    typedef struct {
        int dvd;
        int dvs;
        int q;
        int r;
        int z;
    } vec_t;

    vec_t vecs[9];

    divider_sequential #(
        .DVD_W(DVD_W),
        .DVS_W(DVS_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model straight from unsigned division rules.
    function automatic void model(input int a, input int b,
                                  output int q, output int r, output int z);
        if (b == 0) begin
            q = (1 << DVD_W) - 1;
            r = a % (1 << DVS_W);
            z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
        end
    endfunction

    // Issue one division from IDLE, return results, latency and handshake info.
    task automatic run_div(input int a, input int b,
                           output int q, output int r, output int z,
                           output int lat, output int busy_seen,
                           output int extra_done);
        @(negedge clk);
        dividend  = DVD_W'(a);
        divisor   = DVS_W'(b);
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        lat       = 1;
        busy_seen = 0;
        while (!done && lat < TIMEOUT) begin
            if (busy) busy_seen = 1;
            @(negedge clk);
            lat++;
        end
        q = int'(quotient);
        r = int'(remainder);
        z = int'(div_by_zero);
        if (!done) chk("done_timeout", 0, 1);
        @(negedge clk);
        extra_done = int'(done);
    endtask

    task automatic check_div(input string tag, input int a, input int b);
        int q, r, z, lat, bs, xd;
        int eq, er, ez;
        model(a, b, eq, er, ez);
        run_div(a, b, q, r, z, lat, bs, xd);
        chk({tag, "_quotient"}, q, eq);
        chk({tag, "_remainder"}, r, er);
        chk({tag, "_dbz"}, z, ez);
        chk({tag, "_latency"}, lat, (b == 0) ? 1 : DVD_W + 1);
        chk({tag, "_busy_seen"}, bs, (b == 0) ? 0 : 1);
        chk({tag, "_done_one_cycle"}, xd, 0);
    endtask

    initial begin
        int pulse_t[$];
        int pulse_q[$];
        int pulse_r[$];
        int cyc;
        int seen;

        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        vecs[0] = '{70, 7, 10, 0, 0};
        vecs[1] = '{200, 13, 15, 5, 0};
        vecs[2] = '{255, 1, 255, 0, 0};
        vecs[3] = '{5, 0, 255, 5, 1};
        vecs[4] = '{255, 15, 17, 0, 0};
        vecs[5] = '{0, 5, 0, 0, 0};
        vecs[6] = '{128, 9, 14, 2, 0};
        vecs[7] = '{99, 0, 255, 3, 1};
        vecs[8] = '{3, 15, 0, 3, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_quotient", int'(quotient), 0);
        chk("reset_remainder", int'(remainder), 0);
        chk("reset_dbz", int'(div_by_zero), 0);
        rst = 1'b0;

        // Table vectors with hand-derived expected results.
        for (int i = 0; i < 9; i++) begin
            int q, r, z, lat, bs, xd;
            run_div(vecs[i].dvd, vecs[i].dvs, q, r, z, lat, bs, xd);
            chk($sformatf("vec%0d_quotient", i), q, vecs[i].q);
            chk($sformatf("vec%0d_remainder", i), r, vecs[i].r);
            chk($sformatf("vec%0d_dbz", i), z, vecs[i].z);
            chk($sformatf("vec%0d_latency", i), lat, (vecs[i].dvs == 0) ? 1 : DVD_W + 1);
            chk($sformatf("vec%0d_busy_seen", i), bs, (vecs[i].dvs == 0) ? 0 : 1);
            chk($sformatf("vec%0d_done_one_cycle", i), xd, 0);
        end

        // Last vector was 3/15: results must hold through idle cycles.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_quotient", int'(quotient), 0);
            chk("hold_remainder", int'(remainder), 3);
            chk("hold_done", int'(done), 0);
        end

        // Reset mid-run: start 100/3, assert rst so it is sampled at E4.
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_quotient", int'(quotient), 0);
        chk("abort_remainder", int'(remainder), 0);
        chk("abort_dbz", int'(div_by_zero), 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("abort_no_done", seen, 0);
        check_div("after_abort", 100, 3);

        // Start held high: done every DVD_W+2 cycles, RUN-time operand noise ignored.
        @(negedge clk);
        dividend = 8'd70;
        divisor  = 4'd7;
        start    = 1'b1;
        for (cyc = 0; cyc < 3 * (DVD_W + 2) + 2; cyc++) begin
            @(negedge clk);
            if (done) begin
                pulse_t.push_back(cyc);
                pulse_q.push_back(int'(quotient));
                pulse_r.push_back(int'(remainder));
            end
            if (busy) begin
                dividend = DVD_W'($urandom);
                divisor  = DVS_W'($urandom);
            end else begin
                dividend = 8'd70;
                divisor  = 4'd7;
            end
        end
        start = 1'b0;
        chk("stream_pulses", pulse_t.size(), 3);
        for (int i = 0; i < pulse_t.size(); i++) begin
            chk($sformatf("stream%0d_quotient", i), pulse_q[i], 10);
            chk($sformatf("stream%0d_remainder", i), pulse_r[i], 0);
            if (i > 0) chk($sformatf("stream%0d_period", i), pulse_t[i] - pulse_t[i-1], DVD_W + 2);
        end
        repeat (DVD_W + 3) @(negedge clk);

        // Randomized operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            int a, b;
            a = int'($urandom_range(0, (1 << DVD_W) - 1));
            b = (i % 8 == 0) ? 0 : int'($urandom_range(0, (1 << DVS_W) - 1));
            check_div($sformatf("rand%0d", i), a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
